// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Target side of the byte-serial CPU memory bus. Provides a byte RAM
//            with registered reads, a UART TX FIFO and an RX holding register
//            mapped into the 0x3xxxx I/O window.
// Options  : MEM_RESP_CYCLE_CNT_EN adds a cycle counter readable at 0x30008-B.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sim_end,
  output logic        tx_overflow
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [17:0] IO_UART  = 18'h30000;
  localparam logic [17:0] IO_END   = 18'h30004;
  localparam logic [17:0] IO_CYC0  = 18'h30008;
  localparam logic [17:0] IO_CYC1  = 18'h30009;
  localparam logic [17:0] IO_CYC2  = 18'h3000A;
  localparam logic [17:0] IO_CYC3  = 18'h3000B;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] NEAR_FULL  = CNT_W'(TX_DEPTH - 2);

  logic [7:0] ram_q [0:(1<<ADDR_WIDTH)-1];

  logic [17:0]           io_addr;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  io_sel;
  logic                  unused_addr_hi;
  assign io_addr        = mem_a[17:0];
  assign ram_idx        = mem_a[ADDR_WIDTH-1:0];
  assign io_sel         = (mem_a[17:16] == 2'b11);
  assign unused_addr_hi = ^mem_a[31:18];

  logic io_wr_uart, io_wr_end, io_rd_uart;
  assign io_wr_uart = rdy_in && mem_wr && io_sel && (io_addr == IO_UART);
  assign io_wr_end  = rdy_in && mem_wr && io_sel && (io_addr == IO_END);
  assign io_rd_uart = rdy_in && !mem_wr && io_sel && (io_addr == IO_UART);

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem_q [0:TX_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             io_full_q, overflow_q;
  logic             pop, push_ok, push_drop;

  assign tx_valid  = (count_q != '0);
  assign tx_data   = tx_mem_q[rd_ptr_q];
  assign pop       = rdy_in && tx_valid && tx_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok   = io_wr_uart && ((count_q != FULL_CNT) || pop);
  assign push_drop = io_wr_uart && !push_ok;

  always_comb begin
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) tx_mem_q[wr_ptr_q] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      io_full_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (rdy_in) begin
      if (push_ok)   wr_ptr_q   <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q   <= rd_ptr_q + 1'b1;
      if (push_drop) overflow_q <= 1'b1;
      count_q   <= count_d;
      io_full_q <= (count_d >= NEAR_FULL);
    end
  end

  assign io_buffer_full = io_full_q;
  assign tx_overflow    = overflow_q;

  // ---------------- RX holding register ----------------
  logic       rx_held_q;
  logic [7:0] rx_byte_q;
  logic       rx_cap;

  assign rx_ready = !rx_held_q;
  assign rx_cap   = rdy_in && rx_valid && !rx_held_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_held_q <= 1'b0;
      rx_byte_q <= '0;
    end else if (rx_cap) begin
      rx_held_q <= 1'b1;
      rx_byte_q <= rx_data;
    end else if (io_rd_uart) begin
      rx_held_q <= 1'b0;
    end
  end

  // ---------------- sim_end ----------------
  logic sim_end_q;
  always_ff @(posedge clk_in) begin
    if (rst_in)         sim_end_q <= 1'b0;
    else if (io_wr_end) sim_end_q <= 1'b1;
  end
  assign sim_end = sim_end_q;

`ifdef MEM_RESP_CYCLE_CNT_EN
  logic [31:0] cyc_q, snap_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_q  <= '0;
      snap_q <= '0;
    end else if (rdy_in) begin
      cyc_q <= cyc_q + 32'd1;
      if (!mem_wr && io_sel && (io_addr == IO_CYC0)) snap_q <= cyc_q;
    end
  end
`endif

  // ---------------- read data ----------------
  logic [7:0] io_rdata;
  always_comb begin
    io_rdata = 8'h00;
    case (io_addr)
      IO_UART: io_rdata = rx_held_q ? rx_byte_q : 8'h00;
`ifdef MEM_RESP_CYCLE_CNT_EN
      IO_CYC0: io_rdata = cyc_q[7:0];
      IO_CYC1: io_rdata = snap_q[15:8];
      IO_CYC2: io_rdata = snap_q[23:16];
      IO_CYC3: io_rdata = snap_q[31:24];
`else
      IO_CYC0, IO_CYC1, IO_CYC2, IO_CYC3: io_rdata = 8'h00;
`endif
      default: io_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in && mem_wr && !io_sel) ram_q[ram_idx] <= mem_dout;
  end

  logic [7:0] mem_din_q;
  always_ff @(posedge clk_in) begin
    if (rst_in)      mem_din_q <= 8'h00;
    else if (rdy_in) begin
      if (mem_wr)      mem_din_q <= 8'h00;
      else if (io_sel) mem_din_q <= io_rdata;
      else             mem_din_q <= ram_q[ram_idx];
    end
  end
  assign mem_din = mem_din_q;

endmodule

`default_nettype wire
